// File: rtl/sgd_mem_pkg.sv
// Shared definitions for the SGD memory read path.
// Holds the AXI constants driven on the AR channel, the cache-line geometry,
// the status byte bit positions and the read-command responder state encoding.
package sgd_mem_pkg;

  localparam int unsigned CL_BYTES   = 64;
  localparam int unsigned CL_SHIFT   = 6;
  localparam int unsigned PAGE_SHIFT = 12;
  localparam int unsigned BEAT_W     = 32 - CL_SHIFT;

  localparam logic [2:0] ARSIZE_64B = 3'b110;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned ST_RESP_ERR   = 0;
  localparam int unsigned ST_MISALIGNED = 1;
  localparam int unsigned ST_ZERO_LEN   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_STATUS
  } rd_state_e;

  function automatic logic [7:0] status_code(input logic err, input logic misaligned,
                                             input logic zero_len);
    logic [7:0] s;
    s = '0;
    s[ST_RESP_ERR]   = err;
    s[ST_MISALIGNED] = misaligned;
    s[ST_ZERO_LEN]   = zero_len;
    return s;
  endfunction

endpackage

// File: rtl/mem_rd_cmd_responder_if.sv
// Bus bundle for mem_rd_cmd_responder: command input, AXI-MM AR/R channels,
// output line stream and status stream.
// modport master : the responder's view
// modport slave  : the environment's view (command source, memory, sinks)
interface mem_rd_cmd_responder_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 33
);
  logic                    s_cmd_valid;
  logic                    s_cmd_ready;
  logic [63:0]             s_cmd_address;
  logic [31:0]             s_cmd_length;

  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic [5:0]              m_axi_arid;

  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;

  logic                    m_axis_valid;
  logic                    m_axis_ready;
  logic [DATA_WIDTH-1:0]   m_axis_data;
  logic [DATA_WIDTH/8-1:0] m_axis_keep;
  logic                    m_axis_last;

  logic                    m_status_valid;
  logic                    m_status_ready;
  logic [7:0]              m_status_data;

  modport master (
    input  s_cmd_valid, s_cmd_address, s_cmd_length,
    output s_cmd_ready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output m_axi_rready,
    output m_axis_valid, m_axis_data, m_axis_keep, m_axis_last,
    input  m_axis_ready,
    output m_status_valid, m_status_data,
    input  m_status_ready
  );

  modport slave (
    output s_cmd_valid, s_cmd_address, s_cmd_length,
    input  s_cmd_ready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  m_axi_rready,
    input  m_axis_valid, m_axis_data, m_axis_keep, m_axis_last,
    output m_axis_ready,
    input  m_status_valid, m_status_data,
    output m_status_ready
  );

endinterface

// File: rtl/mem_rd_burst_splitter.sv
// Turns a latched (address, beat count) into a sequence of AR bursts that
// never cross a 4 KB page, while keeping at most MAX_OUTSTANDING bursts open.
// Ports: load/load_addr/load_beats latch a new command; issue_en allows AR
// issue; arready/rlast_hs are the AR and burst-completion handshakes;
// arvalid/araddr/arlen drive the AR channel; beats_zero flags that every
// beat of the command has been requested.
module mem_rd_burst_splitter
  import sgd_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 33,
  parameter int unsigned MAX_BURST_BEATS = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [BEAT_W-1:0]     load_beats,
  input  logic                  issue_en,
  input  logic                  arready,
  input  logic                  rlast_hs,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic                  beats_zero
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0]     beats_rem_q;
  logic [OW-1:0]         out_q;
  logic [BEAT_W-1:0]     room;
  logic [BEAT_W-1:0]     burst_beats;
  logic                  ar_hs;

  // Beats left before the next 4 KB page boundary.
  assign room        = BEAT_W'(MAX_BURST_BEATS) - BEAT_W'(addr_q[PAGE_SHIFT-1:CL_SHIFT]);
  assign burst_beats = (beats_rem_q < room) ? beats_rem_q : room;

  assign beats_zero = (beats_rem_q == '0);
  assign arvalid    = issue_en && !beats_zero && (out_q < OW'(MAX_OUTSTANDING));
  assign araddr     = addr_q;
  assign arlen      = 8'(burst_beats - 1'b1);
  assign ar_hs      = arvalid && arready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      beats_rem_q <= '0;
      out_q       <= '0;
    end else begin
      if (load) begin
        addr_q      <= load_addr;
        beats_rem_q <= load_beats;
      end else if (ar_hs) begin
        addr_q      <= addr_q + (ADDR_WIDTH'(burst_beats) << CL_SHIFT);
        beats_rem_q <= beats_rem_q - burst_beats;
      end
      case ({ar_hs, rlast_hs})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
    end
  end

  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    out_q <= OW'(MAX_OUTSTANDING));

endmodule

// File: rtl/mem_rd_cmd_responder.sv
// Read-command responder: accepts one (byte address, byte length) command,
// issues 4 KB-safe AXI-MM read bursts via mem_rd_burst_splitter, passes the
// returned cache lines straight through to the output stream and reports a
// status byte per command.
// Ports: clk, rst (async, active high); bus (master modport) carries the
// command, AR/R channels, output stream and status stream.
module mem_rd_cmd_responder
  import sgd_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ADDR_WIDTH      = 33,
  parameter int unsigned MAX_BURST_BEATS = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_rd_cmd_responder_if.master bus
);

  rd_state_e         state_q, state_d;
  logic [BEAT_W-1:0] total_q;
  logic [BEAT_W-1:0] fwd_q;
  logic              err_q;
  logic [7:0]        status_q;

  logic cmd_hs, zero_len, misaligned, beat_hs, rlast_hs, beats_zero;
  logic unused_addr_hi;

  assign cmd_hs     = bus.s_cmd_valid && bus.s_cmd_ready;
  assign zero_len   = (bus.s_cmd_length == '0);
  assign misaligned = (|bus.s_cmd_address[CL_SHIFT-1:0]) || (|bus.s_cmd_length[CL_SHIFT-1:0]);
  assign beat_hs    = bus.m_axi_rvalid && bus.m_axi_rready;
  assign rlast_hs   = beat_hs && bus.m_axi_rlast;
  assign unused_addr_hi = ^bus.s_cmd_address[63:ADDR_WIDTH];

  // Outputs are forced low while rst is held so reset takes effect without a clock.
  assign bus.s_cmd_ready    = (state_q == S_IDLE) && !rst;
  assign bus.m_axis_valid   = bus.m_axi_rvalid && !rst;
  assign bus.m_axi_rready   = bus.m_axis_ready && !rst;
  assign bus.m_axis_data    = bus.m_axi_rdata;
  assign bus.m_axis_keep    = '1;
  assign bus.m_axis_last    = (fwd_q == total_q - 1'b1);
  assign bus.m_status_valid = (state_q == S_STATUS);
  assign bus.m_status_data  = status_q;
  assign bus.m_axi_arsize   = ARSIZE_64B;
  assign bus.m_axi_arburst  = BURST_INCR;
  assign bus.m_axi_arid     = '0;

  mem_rd_burst_splitter #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .MAX_BURST_BEATS (MAX_BURST_BEATS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_splitter (
    .clk        (clk),
    .rst        (rst),
    .load       (cmd_hs),
    .load_addr  (bus.s_cmd_address[ADDR_WIDTH-1:0]),
    .load_beats (bus.s_cmd_length[31:CL_SHIFT]),
    .issue_en   (state_q == S_ISSUE),
    .arready    (bus.m_axi_arready),
    .rlast_hs   (rlast_hs),
    .arvalid    (bus.m_axi_arvalid),
    .araddr     (bus.m_axi_araddr),
    .arlen      (bus.m_axi_arlen),
    .beats_zero (beats_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_hs) state_d = (zero_len || misaligned) ? S_STATUS : S_ISSUE;
      S_ISSUE:  if (beats_zero) state_d = S_DRAIN;
      S_DRAIN:  if (fwd_q == total_q) state_d = S_STATUS;
      S_STATUS: if (bus.m_status_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q  <= '0;
      fwd_q    <= '0;
      err_q    <= 1'b0;
      status_q <= '0;
    end else if (cmd_hs) begin
      total_q  <= bus.s_cmd_length[31:CL_SHIFT];
      fwd_q    <= '0;
      err_q    <= 1'b0;
      // Zero length wins over misalignment when both apply.
      status_q <= status_code(1'b0, misaligned && !zero_len, zero_len);
    end else begin
      if (beat_hs) begin
        fwd_q <= fwd_q + 1'b1;
        if (bus.m_axi_rresp != RESP_OKAY) err_q <= 1'b1;
      end
      if (state_q == S_DRAIN && state_d == S_STATUS)
        status_q <= status_code(err_q, 1'b0, 1'b0);
    end
  end

  a_no_r_when_idle: assert property (@(posedge clk) disable iff (rst)
    !(bus.m_axi_rvalid && (state_q == S_IDLE || state_q == S_STATUS)));

endmodule

// File: tb/tb_mem_rd_cmd_responder.sv
// Self-checking bench for mem_rd_cmd_responder: table of directed commands
// with hand-computed AR/beat/status expectations, plus reset sequences.
module tb_mem_rd_cmd_responder;

  logic clk;
  logic rst;

  mem_rd_cmd_responder_if #(.DATA_WIDTH(512), .ADDR_WIDTH(33)) bus ();

  mem_rd_cmd_responder #(
    .DATA_WIDTH      (512),
    .ADDR_WIDTH      (33),
    .MAX_BURST_BEATS (64),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    int          bad_beat;
    int          hold;
    bit          rnd;
    int          exp_nar;
    logic [32:0] ar0_addr;
    logic [7:0]  ar0_len;
    logic [32:0] ar1_addr;
    logic [7:0]  ar1_len;
    int          exp_beats;
    int          exp_ar_first;
    logic [7:0]  exp_status;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  int n_tests;
  int n_fail;

  int          r_nar, r_beats, r_data_err, r_last_err, r_pass_err, r_ostd_err;
  int          r_st_unstable, r_ar_first;
  bit          r_done;
  logic [7:0]  r_status;
  logic [32:0] r_ar_addr[2];
  logic [7:0]  r_ar_len[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input logic [31:0] len, input int bad,
                              input int hold, input bit rnd, input int nar,
                              input logic [32:0] a0, input logic [7:0] l0,
                              input logic [32:0] a1, input logic [7:0] l1,
                              input int beats, input int arf, input logic [7:0] st);
    vec_t v;
    v.addr = addr; v.len = len; v.bad_beat = bad; v.hold = hold; v.rnd = rnd;
    v.exp_nar = nar; v.ar0_addr = a0; v.ar0_len = l0; v.ar1_addr = a1; v.ar1_len = l1;
    v.exp_beats = beats; v.exp_ar_first = arf; v.exp_status = st;
    return v;
  endfunction

  function automatic logic [511:0] pat(input int tag, input int idx);
    logic [31:0] w;
    w = {tag[7:0], idx[23:0]};
    return {16{w}};
  endfunction

  task automatic idle_inputs();
    bus.s_cmd_valid    = 1'b0;
    bus.s_cmd_address  = '0;
    bus.s_cmd_length   = '0;
    bus.m_axi_arready  = 1'b0;
    bus.m_axi_rvalid   = 1'b0;
    bus.m_axi_rdata    = '0;
    bus.m_axi_rresp    = 2'b00;
    bus.m_axi_rlast    = 1'b0;
    bus.m_axis_ready   = 1'b0;
    bus.m_status_ready = 1'b0;
  endtask

  // Drives one command and acts as memory/stream sink/status sink until the
  // status handshake (or until abort_after beats have been accepted).
  task automatic run_cmd(input vec_t v, input int tag, input int abort_after);
    int ar_q[$];
    int rcv, cyc, ostd;
    bit cmd_sent, st_seen, prev_stall;
    logic [7:0]  st_first;
    logic [32:0] prev_addr;
    logic [7:0]  prev_len;
    rcv = 0; cyc = 0; ostd = 0; cmd_sent = 0; st_seen = 0; prev_stall = 0;
    st_first = '0; prev_addr = '0; prev_len = '0;
    r_nar = 0; r_beats = 0; r_data_err = 0; r_last_err = 0; r_pass_err = 0;
    r_ostd_err = 0; r_st_unstable = 0; r_ar_first = -1; r_done = 0; r_status = 'x;
    r_ar_addr[0] = 'x; r_ar_addr[1] = 'x; r_ar_len[0] = 'x; r_ar_len[1] = 'x;
    while (cyc < 3000) begin
      @(negedge clk);
      bus.s_cmd_valid   = !cmd_sent;
      bus.s_cmd_address = v.addr;
      bus.s_cmd_length  = v.len;
      bus.m_axi_arready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axi_rvalid  = (ar_q.size() > 0) && (cyc >= v.hold);
      if (v.rnd && ($urandom_range(0, 3) == 0)) bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rdata   = pat(tag, rcv);
      bus.m_axi_rresp   = (rcv == v.bad_beat) ? 2'b10 : 2'b00;
      bus.m_axi_rlast   = 1'b0;
      if (ar_q.size() > 0) bus.m_axi_rlast = (ar_q[0] == 1);
      bus.m_axis_ready   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_status_ready = v.rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      if (bus.m_axis_valid !== bus.m_axi_rvalid || bus.m_axi_rready !== bus.m_axis_ready ||
          bus.m_axis_data !== bus.m_axi_rdata || bus.m_axis_keep !== '1)
        r_pass_err++;
      if (bus.s_cmd_valid && bus.s_cmd_ready) cmd_sent = 1;
      if (prev_stall && (!bus.m_axi_arvalid || bus.m_axi_araddr !== prev_addr ||
                         bus.m_axi_arlen !== prev_len))
        r_pass_err++;
      if (bus.m_axi_arvalid) begin
        if (ostd >= 4) r_ostd_err++;
        if (bus.m_axi_arsize !== 3'b110 || bus.m_axi_arburst !== 2'b01 || bus.m_axi_arid !== 6'd0)
          r_pass_err++;
      end
      prev_stall = bus.m_axi_arvalid && !bus.m_axi_arready;
      prev_addr  = bus.m_axi_araddr;
      prev_len   = bus.m_axi_arlen;
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        if (r_ar_first < 0) r_ar_first = r_nar;
        if (bus.m_axis_data !== pat(tag, rcv)) r_data_err++;
        if (bus.m_axis_last !== (rcv == v.exp_beats - 1)) r_last_err++;
        rcv++;
        ar_q[0] = ar_q[0] - 1;
        if (ar_q[0] == 0) begin
          void'(ar_q.pop_front());
          ostd--;
        end
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        if (r_nar < 2) begin
          r_ar_addr[r_nar] = bus.m_axi_araddr;
          r_ar_len[r_nar]  = bus.m_axi_arlen;
        end
        r_nar++;
        ostd++;
        ar_q.push_back(int'(bus.m_axi_arlen) + 1);
      end
      if (bus.m_status_valid) begin
        if (!st_seen) begin
          st_seen  = 1;
          st_first = bus.m_status_data;
        end else if (bus.m_status_data !== st_first) r_st_unstable++;
        if (bus.m_status_ready) begin
          r_status = bus.m_status_data;
          r_done   = 1;
          break;
        end
      end
      if (abort_after >= 0 && rcv >= abort_after) begin
        r_done = 1;
        break;
      end
      cyc++;
    end
    r_beats = rcv;
  endtask

  task automatic check_vec(input string p, input vec_t v);
    check({p, " done"}, 64'(r_done), 64'd1);
    check({p, " ar_count"}, r_nar, v.exp_nar);
    if (v.exp_nar >= 1) begin
      check({p, " ar0_addr"}, r_ar_addr[0], v.ar0_addr);
      check({p, " ar0_len"}, r_ar_len[0], v.ar0_len);
    end
    if (v.exp_nar >= 2) begin
      check({p, " ar1_addr"}, r_ar_addr[1], v.ar1_addr);
      check({p, " ar1_len"}, r_ar_len[1], v.ar1_len);
    end
    check({p, " beats"}, r_beats, v.exp_beats);
    check({p, " data_errors"}, r_data_err, 0);
    check({p, " last_errors"}, r_last_err, 0);
    check({p, " passthrough_errors"}, r_pass_err, 0);
    check({p, " outstanding_errors"}, r_ostd_err, 0);
    check({p, " status_unstable"}, r_st_unstable, 0);
    check({p, " status"}, r_status, v.exp_status);
    if (v.exp_ar_first >= 0) check({p, " ars_before_first_r"}, r_ar_first, v.exp_ar_first);
    @(negedge clk);
    idle_inputs();
    #1;
    check({p, " ready_after_status"}, bus.s_cmd_ready, 1'b1);
  endtask

  initial begin
    int quiet_err;
    n_tests = 0;
    n_fail  = 0;

    //           addr                  len           bad hold rnd nar ar0          l0  ar1          l1  beats arf  st
    vecs[0]  = mk(64'h1000,            32'h100,      -1, 0,  0,  1, 33'h1000,  3,  33'h0,     0,  4,   -1, 8'h00);
    vecs[1]  = mk(64'h0FC0,            32'h1040,     -1, 0,  0,  2, 33'h0FC0,  0,  33'h1000,  63, 65,  -1, 8'h00);
    vecs[2]  = mk(64'h20000,           32'h8000,     -1, 30, 0,  8, 33'h20000, 63, 33'h21000, 63, 512, 4,  8'h00);
    vecs[3]  = mk(64'h1004,            32'h40,       -1, 0,  0,  0, 33'h0,     0,  33'h0,     0,  0,   -1, 8'h02);
    vecs[4]  = mk(64'h2000,            32'h0,        -1, 0,  0,  0, 33'h0,     0,  33'h0,     0,  0,   -1, 8'h04);
    vecs[5]  = mk(64'h3000,            32'h100,      1,  0,  0,  1, 33'h3000,  3,  33'h0,     0,  4,   -1, 8'h01);
    vecs[6]  = mk(64'h4F80,            32'hC0,       -1, 0,  1,  2, 33'h4F80,  1,  33'h5000,  0,  3,   -1, 8'h00);
    vecs[7]  = mk(64'h7F00,            32'h200,      -1, 0,  1,  2, 33'h7F00,  3,  33'h8000,  3,  8,   -1, 8'h00);
    vecs[8]  = mk(64'h6_0000_1000,     32'h40,       -1, 0,  0,  1, 33'h1000,  0,  33'h0,     0,  1,   -1, 8'h00);
    vecs[9]  = mk(64'h1000,            32'h41,       -1, 0,  0,  0, 33'h0,     0,  33'h0,     0,  0,   -1, 8'h02);
    vecs[10] = mk(64'h1004,            32'h0,        -1, 0,  0,  0, 33'h0,     0,  33'h0,     0,  0,   -1, 8'h04);

    idle_inputs();
    rst = 1'b1;
    bus.m_axi_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset s_cmd_ready", bus.s_cmd_ready, 1'b0);
    check("reset arvalid", bus.m_axi_arvalid, 1'b0);
    check("reset status_valid", bus.m_status_valid, 1'b0);
    check("reset m_axis_valid", bus.m_axis_valid, 1'b0);
    bus.m_axi_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready after reset release", bus.s_cmd_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i], i + 1, -1);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Async reset in DRAIN: 2 of 4 beats delivered, then reset between edges.
    run_cmd(vecs[0], 40, 2);
    check("abort reached", 64'(r_done), 64'd1);
    @(posedge clk);
    #3;
    bus.m_axi_rvalid   = 1'b1;
    bus.m_status_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst m_axis_valid", bus.m_axis_valid, 1'b0);
    check("midrst rready", bus.m_axi_rready, 1'b0);
    check("midrst s_cmd_ready", bus.s_cmd_ready, 1'b0);
    check("midrst arvalid", bus.m_axi_arvalid, 1'b0);
    check("midrst status_valid", bus.m_status_valid, 1'b0);
    bus.m_axi_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst ready after release", bus.s_cmd_ready, 1'b1);
    quiet_err = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.m_status_valid || bus.m_axi_arvalid) quiet_err++;
    end
    check("midrst no status or AR", quiet_err, 0);

    run_cmd(vecs[1], 50, -1);
    check_vec("post_reset", vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
